// File: rtl/memotable_pkg.sv
// Shared types and defaults for the memo table units (lookup side and recorder).
package memotable_pkg;

    localparam int MEMO_XLEN          = 32;
    localparam int MEMO_MAX_WRITES    = 3;
    localparam int MEMO_REC_MAX_INSNS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        FILL = 2'd2
    } memo_rec_state_e;

    typedef struct packed {
        logic [MEMO_XLEN-1:0]                            start_pc;
        logic [MEMO_XLEN-1:0]                            x1;
        logic [MEMO_XLEN-1:0]                            x10;
        logic [MEMO_XLEN-1:0]                            x11;
        logic [MEMO_XLEN-1:0]                            next_pc;
        logic [MEMO_MAX_WRITES-1:0]                      mask;
        logic [MEMO_MAX_WRITES-1:0][4:0]                 ids;
        logic [MEMO_MAX_WRITES-1:0][MEMO_XLEN-1:0]       vals;
    } memo_fill_t;

endpackage

// File: rtl/memo_wr_coalescer.sv
// Register-write slot array: a write to an already-recorded rd overwrites its slot,
// otherwise it takes the lowest free slot; overflow flags a write with nowhere to go.
module memo_wr_coalescer
    import memotable_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MAX_WRITES = MEMO_MAX_WRITES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [4:0]            wr_rd,
    input  logic [XLEN-1:0]       wr_val,
    output logic [MAX_WRITES-1:0] mask,
    output logic [4:0]            ids  [MAX_WRITES],
    output logic [XLEN-1:0]       vals [MAX_WRITES],
    output logic                  overflow
);

    localparam int IDX_W = (MAX_WRITES > 1) ? $clog2(MAX_WRITES) : 1;

    logic             hit;
    logic             has_free;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;

    // Slots fill contiguously from 0, so the first clear mask bit is the next slot.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = 0; i < MAX_WRITES; i++) begin
            if (mask[i] && (ids[i] == wr_rd) && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!mask[i] && !has_free) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign overflow = wr_en && !hit && !has_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask <= '0;
            for (int i = 0; i < MAX_WRITES; i++) begin
                ids[i]  <= '0;
                vals[i] <= '0;
            end
        end else if (clear) begin
            mask <= '0;
        end else if (wr_en) begin
            if (hit) begin
                vals[hit_idx] <= wr_val;
            end else if (has_free) begin
                mask[free_idx] <= 1'b1;
                ids[free_idx]  <= wr_rd;
                vals[free_idx] <= wr_val;
            end
        end
    end

endmodule

// File: rtl/memo_recorder.sv
// Records one function invocation after a memo miss and offers the resulting
// entry (key, return target, coalesced GPR writes) to the memo table.
module memo_recorder
    import memotable_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MAX_WRITES = MEMO_MAX_WRITES,
    parameter int MAX_INSNS  = MEMO_REC_MAX_INSNS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memo_enable,
    input  logic                  cand_valid,
    output logic                  cand_ready,
    input  logic [XLEN-1:0]       cand_pc,
    input  logic [XLEN-1:0]       snap_x1_ra,
    input  logic [XLEN-1:0]       snap_x10_a0,
    input  logic [XLEN-1:0]       snap_x11_a1,
    input  logic                  ret_valid,
    input  logic [XLEN-1:0]       ret_pc,
    input  logic [XLEN-1:0]       ret_next_pc,
    input  logic                  ret_rd_we,
    input  logic [4:0]            ret_rd,
    input  logic [XLEN-1:0]       ret_rd_val,
    input  logic                  ret_is_store,
    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [XLEN-1:0]       fill_start_pc,
    output logic [XLEN-1:0]       fill_x1,
    output logic [XLEN-1:0]       fill_x10,
    output logic [XLEN-1:0]       fill_x11,
    output logic [XLEN-1:0]       fill_next_pc,
    output logic [MAX_WRITES-1:0] fill_wr_mask,
    output logic [4:0]            fill_wr_ids  [MAX_WRITES],
    output logic [XLEN-1:0]       fill_wr_vals [MAX_WRITES],
    output logic                  busy,
    output logic [31:0]           dbg_commit_count,
    output logic [31:0]           dbg_abort_count
);

    localparam int CNT_W = $clog2(MAX_INSNS + 1);

    memo_rec_state_e state_q, state_d;

    logic [XLEN-1:0]  start_pc_q;
    logic [XLEN-1:0]  x1_q;
    logic [XLEN-1:0]  x10_q;
    logic [XLEN-1:0]  x11_q;
    logic [XLEN-1:0]  next_pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    logic accept;
    logic abort;
    logic to_fill;
    logic commit;
    logic rec_beat;
    logic wr_en;
    logic wr_overflow;
    logic wrong_start;
    logic end_beat;
    logic timeout;
    logic beat_abort;

    assign rec_beat    = (state_q == REC) && ret_valid;
    assign wr_en       = rec_beat && ret_rd_we && (ret_rd != 5'd0);
    assign wrong_start = (cnt_q == '0) && (ret_pc != start_pc_q);
    assign end_beat    = (ret_next_pc == x1_q);
    assign cnt_nxt     = cnt_q + 1'b1;
    assign timeout     = (cnt_nxt == CNT_W'(MAX_INSNS)) && !end_beat;

    // Any fault on a beat outranks that beat returning; the entry would be wrong.
    assign beat_abort  = rec_beat && (ret_is_store || wrong_start || wr_overflow || timeout);

    memo_wr_coalescer #(
        .XLEN       (XLEN),
        .MAX_WRITES (MAX_WRITES)
    ) u_coalescer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .wr_en    (wr_en),
        .wr_rd    (ret_rd),
        .wr_val   (ret_rd_val),
        .mask     (fill_wr_mask),
        .ids      (fill_wr_ids),
        .vals     (fill_wr_vals),
        .overflow (wr_overflow)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        abort   = 1'b0;
        to_fill = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // With recording disabled the candidate is still consumed, just dropped.
                if (cand_valid && memo_enable) begin
                    accept  = 1'b1;
                    state_d = REC;
                end
            end
            REC: begin
                if (!memo_enable || beat_abort) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (rec_beat && end_beat) begin
                    to_fill = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (fill_ready) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            start_pc_q       <= '0;
            x1_q             <= '0;
            x10_q            <= '0;
            x11_q            <= '0;
            next_pc_q        <= '0;
            cnt_q            <= '0;
            dbg_commit_count <= '0;
            dbg_abort_count  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                start_pc_q <= cand_pc;
                x1_q       <= snap_x1_ra;
                x10_q      <= snap_x10_a0;
                x11_q      <= snap_x11_a1;
                cnt_q      <= '0;
            end else if (rec_beat) begin
                cnt_q <= cnt_nxt;
            end
            if (to_fill) begin
                next_pc_q <= ret_next_pc;
            end
            if (commit) begin
                dbg_commit_count <= dbg_commit_count + 32'd1;
            end
            if (abort) begin
                dbg_abort_count <= dbg_abort_count + 32'd1;
            end
        end
    end

    assign cand_ready    = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign fill_valid    = (state_q == FILL);
    assign fill_start_pc = start_pc_q;
    assign fill_x1       = x1_q;
    assign fill_x10      = x10_q;
    assign fill_x11      = x11_q;
    assign fill_next_pc  = next_pc_q;

endmodule

// File: tb/tb_memo_recorder.sv
// Bench for memo_recorder: directed vector table, hand-written corner sequences and
// randomized invocations checked against a transaction-level reference model.
module tb_memo_recorder;
    import memotable_pkg::*;

    localparam int XLEN = 32;
    localparam int MW   = 3;
    localparam int MI   = 16;
    localparam int MAXB = 20;
    localparam logic [31:0] RET_PC = 32'h200;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        store;
    } beat_t;

    typedef struct packed {
        logic [31:0]            start;
        logic [31:0]            x1;
        logic [31:0]            x10;
        logic [31:0]            x11;
        logic [7:0]             nbeats;
        beat_t [MAXB-1:0]       beats;
    } scen_t;

    typedef struct packed {
        logic       commit;
        memo_fill_t fill;
    } res_t;

    typedef struct packed {
        scen_t s;
        res_t  r;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            memo_enable;
    logic            cand_valid;
    logic            cand_ready;
    logic [31:0]     cand_pc;
    logic [31:0]     snap_x1_ra;
    logic [31:0]     snap_x10_a0;
    logic [31:0]     snap_x11_a1;
    logic            ret_valid;
    logic [31:0]     ret_pc;
    logic [31:0]     ret_next_pc;
    logic            ret_rd_we;
    logic [4:0]      ret_rd;
    logic [31:0]     ret_rd_val;
    logic            ret_is_store;
    logic            fill_valid;
    logic            fill_ready;
    logic [31:0]     fill_start_pc;
    logic [31:0]     fill_x1;
    logic [31:0]     fill_x10;
    logic [31:0]     fill_x11;
    logic [31:0]     fill_next_pc;
    logic [MW-1:0]   fill_wr_mask;
    logic [4:0]      fill_wr_ids  [MW];
    logic [31:0]     fill_wr_vals [MW];
    logic            busy;
    logic [31:0]     dbg_commit_count;
    logic [31:0]     dbg_abort_count;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_commit;
    logic [31:0] exp_abort;
    vec_t        tbl[$];

    always #5 clk = ~clk;

    memo_recorder #(
        .XLEN       (XLEN),
        .MAX_WRITES (MW),
        .MAX_INSNS  (MI)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .memo_enable      (memo_enable),
        .cand_valid       (cand_valid),
        .cand_ready       (cand_ready),
        .cand_pc          (cand_pc),
        .snap_x1_ra       (snap_x1_ra),
        .snap_x10_a0      (snap_x10_a0),
        .snap_x11_a1      (snap_x11_a1),
        .ret_valid        (ret_valid),
        .ret_pc           (ret_pc),
        .ret_next_pc      (ret_next_pc),
        .ret_rd_we        (ret_rd_we),
        .ret_rd           (ret_rd),
        .ret_rd_val       (ret_rd_val),
        .ret_is_store     (ret_is_store),
        .fill_valid       (fill_valid),
        .fill_ready       (fill_ready),
        .fill_start_pc    (fill_start_pc),
        .fill_x1          (fill_x1),
        .fill_x10         (fill_x10),
        .fill_x11         (fill_x11),
        .fill_next_pc     (fill_next_pc),
        .fill_wr_mask     (fill_wr_mask),
        .fill_wr_ids      (fill_wr_ids),
        .fill_wr_vals     (fill_wr_vals),
        .busy             (busy),
        .dbg_commit_count (dbg_commit_count),
        .dbg_abort_count  (dbg_abort_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_fill(input memo_fill_t f, input string tag);
        check({tag, ".start_pc"}, fill_start_pc, f.start_pc);
        check({tag, ".x1"}, fill_x1, f.x1);
        check({tag, ".x10"}, fill_x10, f.x10);
        check({tag, ".x11"}, fill_x11, f.x11);
        check({tag, ".next_pc"}, fill_next_pc, f.next_pc);
        check({tag, ".mask"}, 32'(fill_wr_mask), 32'(f.mask));
        for (int k = 0; k < MW; k++) begin
            if (f.mask[k]) begin
                check($sformatf("%s.id%0d", tag, k), 32'(fill_wr_ids[k]), 32'(f.ids[k]));
                check($sformatf("%s.val%0d", tag, k), fill_wr_vals[k], f.vals[k]);
            end
        end
    endtask

    task automatic do_reset();
        cand_valid = 1'b0;
        fill_ready = 1'b0;
        ret_valid  = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n      = 1'b1;
        exp_commit = '0;
        exp_abort  = '0;
    endtask

    // Candidate handshake followed by the scenario's retire beats, with random bubbles.
    task automatic drive(input scen_t s);
        beat_t b;
        cand_valid  = 1'b1;
        memo_enable = 1'b1;
        cand_pc     = s.start;
        snap_x1_ra  = s.x1;
        snap_x10_a0 = s.x10;
        snap_x11_a1 = s.x11;
        step();
        cand_valid = 1'b0;
        for (int i = 0; i < int'(s.nbeats); i++) begin
            b = s.beats[i];
            if ($urandom_range(0, 3) == 0) begin
                ret_valid = 1'b0;
                step();
            end
            ret_valid    = 1'b1;
            ret_pc       = b.pc;
            ret_next_pc  = b.next_pc;
            ret_rd_we    = b.we;
            ret_rd       = b.rd;
            ret_rd_val   = b.val;
            ret_is_store = b.store;
            step();
        end
        ret_valid    = 1'b0;
        ret_rd_we    = 1'b0;
        ret_is_store = 1'b0;
    endtask

    task automatic run_vec(input scen_t s, input res_t r, input int hold, input string tag);
        check({tag, ".idle_before"}, 32'(busy), 32'd0);
        if (busy) do_reset();
        drive(s);
        check({tag, ".fill_valid"}, 32'(fill_valid), 32'(r.commit));
        if (r.commit) begin
            chk_fill(r.fill, tag);
            for (int k = 0; k < hold; k++) begin
                fill_ready  = 1'b0;
                memo_enable = (k % 2) == 1;
                cand_valid  = 1'b1;
                step();
                check({tag, ".hold_valid"}, 32'(fill_valid), 32'd1);
                check({tag, ".hold_cand_ready"}, 32'(cand_ready), 32'd0);
                chk_fill(r.fill, {tag, ".hold"});
            end
            cand_valid  = 1'b0;
            memo_enable = 1'b1;
            fill_ready  = 1'b1;
            step();
            fill_ready = 1'b0;
            exp_commit = exp_commit + 32'd1;
        end else begin
            exp_abort = exp_abort + 32'd1;
        end
        check({tag, ".cand_ready"}, 32'(cand_ready), 32'd1);
        check({tag, ".commits"}, dbg_commit_count, exp_commit);
        check({tag, ".aborts"}, dbg_abort_count, exp_abort);
    endtask

    // Whole-invocation model: walks the beats with a queue of recorded writes.
    function automatic void model(input scen_t s, output res_t r, output int stop);
        logic [4:0]  qid[$];
        logic [31:0] qval[$];
        beat_t       b;
        logic        bad;
        int          hit;
        r = '0;
        r.fill.start_pc = s.start;
        r.fill.x1       = s.x1;
        r.fill.x10      = s.x10;
        r.fill.x11      = s.x11;
        stop = -1;
        for (int i = 0; i < int'(s.nbeats); i++) begin
            b   = s.beats[i];
            bad = b.store || (i == 0 && b.pc != s.start);
            if (!bad && b.we && b.rd != 5'd0) begin
                hit = -1;
                foreach (qid[k]) if (qid[k] == b.rd) hit = k;
                if (hit >= 0) qval[hit] = b.val;
                else if (qid.size() < MW) begin
                    qid.push_back(b.rd);
                    qval.push_back(b.val);
                end else bad = 1'b1;
            end
            if (bad) begin
                stop = i;
                return;
            end
            if (b.next_pc == s.x1) begin
                r.commit       = 1'b1;
                r.fill.next_pc = b.next_pc;
                foreach (qid[k]) begin
                    r.fill.mask[k] = 1'b1;
                    r.fill.ids[k]  = qid[k];
                    r.fill.vals[k] = qval[k];
                end
                stop = i;
                return;
            end
            if (i + 1 == MI) begin
                stop = i;
                return;
            end
        end
    endfunction

    function automatic beat_t sq(input int i, input bit we, input int rd, input int val,
                                 input bit st, input bit e);
        beat_t b;
        b.pc      = 32'h100 + 32'(4 * i);
        b.next_pc = e ? RET_PC : b.pc + 32'd4;
        b.we      = we;
        b.rd      = 5'(rd);
        b.val     = 32'(val);
        b.store   = st;
        return b;
    endfunction

    function automatic scen_t base_scen(input int k);
        scen_t s;
        s       = '0;
        s.start = 32'h100;
        s.x1    = RET_PC;
        s.x10   = 32'h1000 + 32'(k);
        s.x11   = 32'h2000 + 32'(k);
        return s;
    endfunction

    function automatic res_t exp_res(input scen_t s, input bit c, input logic [2:0] m,
                                     input int i0, input int i1, input int i2,
                                     input int v0, input int v1, input int v2);
        res_t r;
        r                = '0;
        r.commit         = c;
        r.fill.start_pc  = s.start;
        r.fill.x1        = s.x1;
        r.fill.x10       = s.x10;
        r.fill.x11       = s.x11;
        r.fill.next_pc   = c ? RET_PC : 32'd0;
        r.fill.mask      = m;
        r.fill.ids[0]    = 5'(i0);
        r.fill.ids[1]    = 5'(i1);
        r.fill.ids[2]    = 5'(i2);
        r.fill.vals[0]   = 32'(v0);
        r.fill.vals[1]   = 32'(v1);
        r.fill.vals[2]   = 32'(v2);
        return r;
    endfunction

    task automatic add(input scen_t s, input res_t r);
        vec_t v;
        v.s = s;
        v.r = r;
        tbl.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        scen_t s;
        res_t  r;
        beat_t b;
        int    stop;
        int    len;
        bit    no_end;

        n_cmp = 0; n_fail = 0; exp_commit = '0; exp_abort = '0;
        memo_enable = 1'b0; cand_valid = 1'b0; cand_pc = '0;
        snap_x1_ra = '0; snap_x10_a0 = '0; snap_x11_a1 = '0;
        ret_valid = 1'b0; ret_pc = '0; ret_next_pc = '0; ret_rd_we = 1'b0;
        ret_rd = '0; ret_rd_val = '0; ret_is_store = 1'b0; fill_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        check("rst.fill_valid", 32'(fill_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.cand_ready", 32'(cand_ready), 32'd1);
        check("rst.commits", dbg_commit_count, 32'd0);
        check("rst.aborts", dbg_abort_count, 32'd0);
        check("rst.id0", 32'(fill_wr_ids[0]), 32'd0);
        check("rst.val0", fill_wr_vals[0], 32'd0);
        chk_fill('0, "rst");

        // basic commit
        s = base_scen(0);
        s.beats[0] = sq(0, 1, 10, 5, 0, 0);
        s.beats[1] = sq(1, 1, 11, 7, 0, 0);
        s.beats[2] = sq(2, 0, 0, 0, 0, 1);
        s.nbeats = 8'd3;
        add(s, exp_res(s, 1, 3'b011, 10, 11, 0, 5, 7, 0));
        // coalescing and x0
        s = base_scen(1);
        s.beats[0] = sq(0, 1, 10, 1, 0, 0);
        s.beats[1] = sq(1, 1, 0, 9, 0, 0);
        s.beats[2] = sq(2, 1, 10, 3, 0, 0);
        s.beats[3] = sq(3, 1, 5, 4, 0, 0);
        s.beats[4] = sq(4, 1, 6, 8, 0, 0);
        s.beats[5] = sq(5, 1, 10, 2, 0, 0);
        s.beats[6] = sq(6, 0, 0, 0, 0, 1);
        s.nbeats = 8'd7;
        add(s, exp_res(s, 1, 3'b111, 10, 5, 6, 2, 4, 8));
        // four distinct writes
        s = base_scen(2);
        for (int i = 0; i < 4; i++) s.beats[i] = sq(i, 1, 5 + i, i + 1, 0, 0);
        s.nbeats = 8'd4;
        add(s, exp_res(s, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // store on second beat
        s = base_scen(3);
        s.beats[0] = sq(0, 1, 5, 1, 0, 0);
        s.beats[1] = sq(1, 0, 0, 0, 1, 0);
        s.nbeats = 8'd2;
        add(s, exp_res(s, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // overflow on the returning beat
        s = base_scen(4);
        for (int i = 0; i < 3; i++) s.beats[i] = sq(i, 1, 5 + i, i + 1, 0, 0);
        s.beats[3] = sq(3, 1, 8, 4, 0, 1);
        s.nbeats = 8'd4;
        add(s, exp_res(s, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // wrong first pc
        s = base_scen(5);
        s.beats[0] = sq(1, 1, 10, 1, 0, 0);
        s.nbeats = 8'd1;
        add(s, exp_res(s, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // 16 beats with no return
        s = base_scen(6);
        for (int i = 0; i < 16; i++) s.beats[i] = sq(i, 0, 0, 0, 0, 0);
        s.nbeats = 8'd16;
        add(s, exp_res(s, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        // return exactly on the 16th beat
        s = base_scen(7);
        for (int i = 0; i < 15; i++) s.beats[i] = sq(i, 0, 0, 0, 0, 0);
        s.beats[15] = sq(15, 1, 3, 51, 0, 1);
        s.nbeats = 8'd16;
        add(s, exp_res(s, 1, 3'b001, 3, 0, 0, 51, 0, 0));
        // returning beat's write lands before the entry is frozen
        s = base_scen(8);
        s.beats[0] = sq(0, 1, 10, 1, 0, 0);
        s.beats[1] = sq(1, 1, 10, 9, 0, 1);
        s.nbeats = 8'd2;
        add(s, exp_res(s, 1, 3'b001, 10, 0, 0, 9, 0, 0));
        // store on the returning beat
        s = base_scen(9);
        s.beats[0] = sq(0, 0, 0, 0, 1, 1);
        s.nbeats = 8'd1;
        add(s, exp_res(s, 0, 3'b000, 0, 0, 0, 0, 0, 0));

        foreach (tbl[n]) run_vec(tbl[n].s, tbl[n].r, 0, $sformatf("vec%0d", n));

        run_vec(tbl[0].s, tbl[0].r, 5, "bp");

        // disabled candidate is consumed and dropped
        cand_valid  = 1'b1;
        memo_enable = 1'b0;
        cand_pc     = 32'h100;
        step();
        cand_valid  = 1'b0;
        memo_enable = 1'b1;
        check("drop.busy", 32'(busy), 32'd0);
        check("drop.aborts", dbg_abort_count, exp_abort);

        // enable falling mid-recording
        s = tbl[0].s;
        s.nbeats = 8'd1;
        drive(s);
        check("en_fall.busy_rec", 32'(busy), 32'd1);
        memo_enable = 1'b0;
        step();
        memo_enable = 1'b1;
        exp_abort = exp_abort + 32'd1;
        check("en_fall.busy", 32'(busy), 32'd0);
        check("en_fall.aborts", dbg_abort_count, exp_abort);

        // reset while recording
        drive(s);
        check("rst_rec.busy_before", 32'(busy), 32'd1);
        do_reset();
        check("rst_rec.busy", 32'(busy), 32'd0);
        check("rst_rec.cand_ready", 32'(cand_ready), 32'd1);
        check("rst_rec.commits", dbg_commit_count, 32'd0);
        check("rst_rec.aborts", dbg_abort_count, 32'd0);
        check("rst_rec.start_pc", fill_start_pc, 32'd0);

        // reset while offering a fill
        run_vec(tbl[0].s, tbl[0].r, 0, "pre_rst_fill");
        drive(tbl[0].s);
        check("rst_fill.valid_before", 32'(fill_valid), 32'd1);
        do_reset();
        check("rst_fill.valid", 32'(fill_valid), 32'd0);
        fill_ready = 1'b1;
        step();
        fill_ready = 1'b0;
        check("rst_fill.valid_after", 32'(fill_valid), 32'd0);
        check("rst_fill.commits", dbg_commit_count, 32'd0);
        check("rst_fill.aborts", dbg_abort_count, 32'd0);

        for (int n = 0; n < 250; n++) begin
            s        = '0;
            s.start  = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
            s.x1     = 32'h8000_0000 | ($urandom & 32'h0fff_fffc);
            s.x10    = $urandom;
            s.x11    = $urandom;
            no_end   = ($urandom_range(0, 3) == 0);
            len      = no_end ? int'($urandom_range(14, MAXB)) : int'($urandom_range(1, MAXB));
            for (int i = 0; i < len; i++) begin
                b.pc = s.start + 32'(4 * i);
                if (i == 0 && $urandom_range(0, 15) == 0) b.pc = b.pc + 32'd4;
                b.we    = 1'($urandom_range(0, 1));
                b.rd    = 5'($urandom_range(0, 7));
                b.val   = $urandom;
                b.store = ($urandom_range(0, 39) == 0);
                b.next_pc = ((i == len - 1 && len < MI) || (!no_end && $urandom_range(0, 7) == 0))
                            ? s.x1 : b.pc + 32'd4;
                s.beats[i] = b;
            end
            s.nbeats = 8'(len);
            model(s, r, stop);
            if (stop < 0) stop = len - 1;
            s.nbeats = 8'(stop + 1);
            run_vec(s, r, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/memo_recorder.md
# memo_recorder

Write-side companion to `memounit`: records one function invocation on a memo miss and emits a table entry. It latches the start PC and live x1/x10/x11 key, watches the retirement stream, and coalesces up to `MAX_WRITES` distinct GPR writes. When the function returns (a retired `next_pc` equals the latched x1), it offers a fill to the memo table over a valid/ready handshake. It sits beside the core shell, fed by memo-miss candidates and retirement.

## Interface
- `XLEN`, 32, data/PC width
- `MAX_WRITES`, `MEMO_MAX_WRITES` (3), recorded register-write slots
- `MAX_INSNS`, 16, retired-instruction budget before abort (≥2)
- `clk` in 1: single clock
- `rst_n` in 1: synchronous, active-low reset
- `memo_enable` in 1: recording permitted
- `cand_valid` in 1 / `cand_ready` out 1: candidate handshake; `cand_ready` = state IDLE
- `cand_pc` in XLEN: candidate start PC
- `snap_x1_ra`, `snap_x10_a0`, `snap_x11_a1` in XLEN each: live key registers, sampled on candidate accept
- `ret_valid` in 1: one instruction retired this cycle
- `ret_pc`, `ret_next_pc` in XLEN: retired PC and its successor
- `ret_rd_we` in 1, `ret_rd` in 5, `ret_rd_val` in XLEN: retired GPR write
- `ret_is_store` in 1: retired instruction has a memory side effect
- `fill_valid` out 1 / `fill_ready` in 1: table-fill handshake
- `fill_start_pc`, `fill_x1`, `fill_x10`, `fill_x11`, `fill_next_pc` out XLEN: entry key and target
- `fill_wr_mask` out MAX_WRITES, `fill_wr_ids[MAX_WRITES]` out 5, `fill_wr_vals[MAX_WRITES]` out XLEN: entry writes
- `busy` out 1: state ≠ IDLE
- `dbg_commit_count`, `dbg_abort_count` out 32: saturating-free wrapping counters

## Operation
- States: IDLE, REC, FILL.
- IDLE→REC: `cand_valid && cand_ready && memo_enable`. Latch `cand_pc`, the three snapshots, clear mask, insn count := 0. `cand_valid` with `memo_enable`=0 is accepted and dropped.
- REC, per `ret_valid` beat:
  - The first beat must have `ret_pc == start_pc`, else abort.
  - `ret_is_store` → abort.
  - GPR write with `ret_rd == 0` is ignored.
  - Write with `ret_rd` equal to a valid slot's id overwrites that slot's value.
  - Otherwise the write fills the lowest free slot; no free slot → abort.
  - Insn count increments. If the count reaches `MAX_INSNS` without an end beat → abort.
  - End beat: `ret_next_pc == fill_x1`. Apply that beat's write first, latch `fill_next_pc := ret_next_pc`, go to FILL.
- Abort priority on the same beat: store = overflow = wrong start > end. Abort → IDLE, `dbg_abort_count`++, entry discarded.
- `memo_enable` falling in REC → abort next edge. FILL is unaffected by `memo_enable`.
- FILL: `fill_valid`=1 and all `fill_*` stable until `fill_ready`. On handshake → IDLE, `dbg_commit_count`++.
- `ret_valid` beats during IDLE/FILL are ignored.

## Timing
- Reset (`rst_n`=0 at posedge):
  - state IDLE
  - `fill_valid`=0, `busy`=0, `cand_ready`=1
  - all `fill_*` fields 0, mask 0
  - both counters 0
- Reset during REC/FILL discards the entry, with no counter change.
- Candidate accepted at edge N: the first retire beat considered is the one sampled at edge N+1.
- End beat at edge M: `fill_valid`=1 from cycle M+1. `fill_ready` already high gives handshake at edge M+1, and `cand_ready` is 1 in cycle M+2.
- Abort at edge M: IDLE in cycle M+1, so a new candidate can be accepted at edge M+1.
- Slot order is allocation order. Mask bits are contiguous from bit 0.
- Counters wrap at 2^32.

## Structure
- Add to `memotable_pkg`:
  - `memo_rec_state_e` (IDLE/REC/FILL)
  - `memo_fill_t` struct: start_pc, x1, x10, x11, next_pc, mask, ids, vals
  - `MEMO_REC_MAX_INSNS` default
- Reuse `MEMO_MAX_WRITES`.
- One sub-module, `memo_wr_coalescer`: slot array with CAM-match, overwrite/allocate, overflow flag. The FSM and handshakes stay in `memo_recorder`.

## Test plan
- **Basic commit:** accept cand 0x100 with x1=0x200. Retire 0x100 (x10:=5), 0x104 (x11:=7), 0x108 with next 0x200. Expect one fill: start 0x100, next_pc 0x200, mask 011, ids {10,11}, vals {5,7}, commit=1.
- **Coalesce/x0:**
  - Writes: x10:=1, x0:=9, x10:=3, x5:=4, x6:=8, x10:=2; end.
  - Expect mask 111, ids {10,5,6}, vals {2,4,8}.
- **Overflow and store:**
  - Four distinct rd writes → abort=1, no `fill_valid`.
  - Separate run: store on beat 2 → abort.
  - Separate run: overflow coincident with the end beat → abort, not fill.
- **Wrong start / timeout:**
  - First beat `ret_pc`=0x104 vs start 0x100 → abort.
  - Separate run: 16 beats with no return → abort on the 16th.
- **Backpressure:** hold `fill_ready`=0 for 5 cycles.
  - Fields stay stable, `cand_ready`=0, `memo_enable` toggling has no effect.
  - Handshake on the 6th cycle; IDLE the next cycle.
- **Reset mid-op:**
  - `rst_n`=0 during REC → IDLE, counters 0.
  - `rst_n`=0 during FILL → `fill_valid` drops next cycle, no commit counted.
